// File: rtl/axil_bcast_wr_pkg.sv
// Shared AXI-lite constants: response codes, broadcaster state encoding, response merge helper.
package axil_bcast_wr_pkg;

  localparam int unsigned RESP_WIDTH = 2;

  typedef logic [RESP_WIDTH-1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ISSUE = 3'b010,
    ST_RESP  = 3'b100
  } state_t;

  // Severity order matches the numeric encoding, so the worse response is the larger code.
  function automatic resp_t resp_max(input resp_t a, input resp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axil_bcast_wr_if.sv
// AXI4-lite write channels for N ports, flattened per field; port i occupies slice i of each field.
interface axil_bcast_wr_if #(
  parameter int unsigned N          = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic [N*ADDR_WIDTH-1:0] awaddr;
  logic [N*3-1:0]          awprot;
  logic [N-1:0]            awvalid;
  logic [N-1:0]            awready;
  logic [N*DATA_WIDTH-1:0] wdata;
  logic [N*STRB_WIDTH-1:0] wstrb;
  logic [N-1:0]            wvalid;
  logic [N-1:0]            wready;
  logic [N*2-1:0]          bresp;
  logic [N-1:0]            bvalid;
  logic [N-1:0]            bready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axil_bcast_wr_lane.sv
// Per-master write tracker: drives AW/W valids and B ready for one lane and records its response.
module axil_bcast_wr_lane
  import axil_bcast_wr_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  logic  sel,
  input  logic  awready,
  input  logic  wready,
  input  logic  bvalid,
  input  resp_t bresp,
  output logic  awvalid,
  output logic  wvalid,
  output logic  bready,
  output logic  done_c,
  output resp_t resp_c
);

  logic  aw_done;
  logic  w_done;
  logic  done;
  resp_t resp;

  logic aw_fin_c;
  logic w_fin_c;
  logic b_hs_c;

  assign aw_fin_c = aw_done | (awvalid & awready);
  assign w_fin_c  = w_done | (wvalid & wready);
  assign b_hs_c   = bready & bvalid;

  // Look-ahead views so the top can leave ISSUE on the same edge as the last B handshake.
  assign done_c = done | b_hs_c;
  assign resp_c = b_hs_c ? bresp : resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      done    <= 1'b0;
      resp    <= RESP_OKAY;
    end else if (start) begin
      // An unselected lane is born complete so it never touches its master.
      awvalid <= sel;
      wvalid  <= sel;
      bready  <= 1'b0;
      aw_done <= ~sel;
      w_done  <= ~sel;
      done    <= ~sel;
      resp    <= RESP_OKAY;
    end else begin
      if (awvalid && awready) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (wvalid && wready) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
      if (b_hs_c) begin
        bready <= 1'b0;
        done   <= 1'b1;
        resp   <= bresp;
      end else if (aw_fin_c && w_fin_c && !done && !bready) begin
        bready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_bcast_wr.sv
// AXI4-lite write broadcaster: one slave write is replayed to every enabled master lane and the
// worst of the lane responses is returned once all of them have answered.
module axil_bcast_wr
  import axil_bcast_wr_pkg::*;
#(
  parameter int unsigned M_COUNT    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [M_COUNT-1:0] m_enable,
  axil_bcast_wr_if.slave     s_axil,
  axil_bcast_wr_if.master    m_axil,
  output logic               busy
);

  state_t                  state;
  logic                    aw_cap;
  logic                    w_cap;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              prot_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [STRB_WIDTH-1:0]   strb_q;

  logic                    aw_hs_c;
  logic                    w_hs_c;
  logic                    aw_fin_c;
  logic                    w_fin_c;
  logic                    start_c;
  logic [ADDR_WIDTH-1:0]   cap_addr_c;
  logic [2:0]              cap_prot_c;
  logic [DATA_WIDTH-1:0]   cap_data_c;
  logic [STRB_WIDTH-1:0]   cap_strb_c;

  logic [M_COUNT-1:0]      lane_awvalid;
  logic [M_COUNT-1:0]      lane_wvalid;
  logic [M_COUNT-1:0]      lane_bready;
  logic [M_COUNT-1:0]      lane_done_c;
  resp_t                   lane_resp_c [M_COUNT];
  logic                    all_done_c;
  resp_t                   merged_c;

  assign aw_hs_c  = s_axil.awready[0] & s_axil.awvalid[0];
  assign w_hs_c   = s_axil.wready[0] & s_axil.wvalid[0];
  assign aw_fin_c = aw_cap | aw_hs_c;
  assign w_fin_c  = w_cap | w_hs_c;
  assign start_c  = (state == ST_IDLE) && aw_fin_c && w_fin_c;

  // A channel handshaking in the capture cycle bypasses its holding register.
  assign cap_addr_c = aw_hs_c ? s_axil.awaddr : addr_q;
  assign cap_prot_c = aw_hs_c ? s_axil.awprot : prot_q;
  assign cap_data_c = w_hs_c ? s_axil.wdata : data_q;
  assign cap_strb_c = w_hs_c ? s_axil.wstrb : strb_q;

  for (genvar i = 0; i < M_COUNT; i++) begin : g_lane
    axil_bcast_wr_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .start   (start_c),
      .sel     (m_enable[i]),
      .awready (m_axil.awready[i]),
      .wready  (m_axil.wready[i]),
      .bvalid  (m_axil.bvalid[i]),
      .bresp   (m_axil.bresp[2*i +: 2]),
      .awvalid (lane_awvalid[i]),
      .wvalid  (lane_wvalid[i]),
      .bready  (lane_bready[i]),
      .done_c  (lane_done_c[i]),
      .resp_c  (lane_resp_c[i])
    );
  end

  assign m_axil.awvalid = lane_awvalid;
  assign m_axil.wvalid  = lane_wvalid;
  assign m_axil.bready  = lane_bready;
  assign all_done_c     = &lane_done_c;

  always_comb begin
    merged_c = RESP_OKAY;
    for (int unsigned i = 0; i < M_COUNT; i++) begin
      merged_c = resp_max(merged_c, lane_resp_c[i]);
    end
  end

  // Transaction sequencer and all slave-side / broadcast payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      aw_cap         <= 1'b0;
      w_cap          <= 1'b0;
      addr_q         <= '0;
      prot_q         <= '0;
      data_q         <= '0;
      strb_q         <= '0;
      s_axil.awready <= 1'b0;
      s_axil.wready  <= 1'b0;
      s_axil.bvalid  <= 1'b0;
      s_axil.bresp   <= RESP_OKAY;
      m_axil.awaddr  <= '0;
      m_axil.awprot  <= '0;
      m_axil.wdata   <= '0;
      m_axil.wstrb   <= '0;
      busy           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aw_hs_c) begin
            addr_q <= s_axil.awaddr;
            prot_q <= s_axil.awprot;
          end
          if (w_hs_c) begin
            data_q <= s_axil.wdata;
            strb_q <= s_axil.wstrb;
          end
          if (start_c) begin
            aw_cap         <= 1'b0;
            w_cap          <= 1'b0;
            s_axil.awready <= 1'b0;
            s_axil.wready  <= 1'b0;
            busy           <= 1'b1;
            if (m_enable == '0) begin
              state         <= ST_RESP;
              s_axil.bvalid <= 1'b1;
              s_axil.bresp  <= RESP_DECERR;
            end else begin
              state         <= ST_ISSUE;
              m_axil.awaddr <= {M_COUNT{cap_addr_c}};
              m_axil.awprot <= {M_COUNT{cap_prot_c}};
              m_axil.wdata  <= {M_COUNT{cap_data_c}};
              m_axil.wstrb  <= {M_COUNT{cap_strb_c}};
            end
          end else begin
            aw_cap         <= aw_fin_c;
            w_cap          <= w_fin_c;
            s_axil.awready <= ~aw_fin_c;
            s_axil.wready  <= ~w_fin_c;
          end
        end
        ST_ISSUE: begin
          if (all_done_c) begin
            state         <= ST_RESP;
            s_axil.bvalid <= 1'b1;
            s_axil.bresp  <= merged_c;
          end
        end
        ST_RESP: begin
          if (s_axil.bready[0]) begin
            state          <= ST_IDLE;
            s_axil.bvalid  <= 1'b0;
            s_axil.awready <= 1'b1;
            s_axil.wready  <= 1'b1;
            busy           <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_bcast_wr.sv
// Directed self-checking bench for axil_bcast_wr with an auto-responding model of four masters.
module tb_axil_bcast_wr;
  import axil_bcast_wr_pkg::*;

  localparam int M  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [M-1:0] m_enable;
  logic         busy;

  axil_bcast_wr_if #(.N(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
  axil_bcast_wr_if #(.N(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

  axil_bcast_wr #(
    .M_COUNT    (M),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .STRB_WIDTH (DW / 8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_enable (m_enable),
    .s_axil   (s_if),
    .m_axil   (m_if),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Master model state and configuration
  int          aw_cnt[M];
  int          w_cnt[M];
  int          b_cnt[M];
  int          b_cyc[M];
  int          go_cyc[M];
  bit          pend[M];
  int          b_delay[M];
  logic [1:0]  resp_cfg[M];
  logic [M-1:0] aw_rdy_en;
  int          aw_base[M];
  int          w_base[M];
  int          b_base[M];

  // Slave-side observations
  int s_aw_n = 0, s_w_n = 0, s_aw_cyc = 0, s_w_cyc = 0, bv_cyc = 0;
  bit prev_bv = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < M; i++) begin
      if (rst) begin
        aw_cnt[i] = 0;
        w_cnt[i]  = 0;
        b_cnt[i]  = 0;
        pend[i]   = 1'b0;
      end else begin
        if (m_if.awvalid[i] && m_if.awready[i]) aw_cnt[i]++;
        if (m_if.wvalid[i] && m_if.wready[i]) w_cnt[i]++;
        if (m_if.bvalid[i] && m_if.bready[i]) begin
          b_cnt[i]++;
          b_cyc[i] = cyc;
          pend[i]  = 1'b0;
        end
        if (!pend[i] && aw_cnt[i] > b_cnt[i] && w_cnt[i] > b_cnt[i]) begin
          pend[i]   = 1'b1;
          go_cyc[i] = cyc + 1 + b_delay[i];
        end
      end
    end
    if (s_if.awvalid[0] && s_if.awready[0]) begin s_aw_n++; s_aw_cyc = cyc; end
    if (s_if.wvalid[0] && s_if.wready[0]) begin s_w_n++; s_w_cyc = cyc; end
    if (s_if.bvalid[0] && !prev_bv) bv_cyc = cyc;
    prev_bv = s_if.bvalid[0];
    cyc++;
  end

  always @(negedge clk) begin
    for (int i = 0; i < M; i++) begin
      m_if.awready[i]      = aw_rdy_en[i];
      m_if.wready[i]       = 1'b1;
      m_if.bvalid[i]       = pend[i] && (cyc >= go_cyc[i]);
      m_if.bresp[2*i +: 2] = resp_cfg[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < M; i++) begin
      aw_base[i] = aw_cnt[i];
      w_base[i]  = w_cnt[i];
      b_base[i]  = b_cnt[i];
    end
  endtask

  // Per-lane handshake counts since snap(), one byte per lane (lane 0 in the low byte).
  function automatic logic [31:0] delta(input int kind);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < M; i++) begin
      case (kind)
        0:       v[8*i +: 8] = 8'(aw_cnt[i] - aw_base[i]);
        1:       v[8*i +: 8] = 8'(w_cnt[i] - w_base[i]);
        default: v[8*i +: 8] = 8'(b_cnt[i] - b_base[i]);
      endcase
    end
    return v;
  endfunction

  function automatic int cap_cyc();
    return (s_aw_cyc > s_w_cyc) ? s_aw_cyc : s_w_cyc;
  endfunction

  task automatic send(input bit do_aw, input bit do_w, input string tag);
    int a0, w0;
    a0 = s_aw_n;
    w0 = s_w_n;
    s_if.awvalid = do_aw;
    s_if.wvalid  = do_w;
    for (int k = 0; k < 50 && (s_if.awvalid[0] || s_if.wvalid[0]); k++) begin
      step();
      if (s_aw_n != a0) s_if.awvalid = 1'b0;
      if (s_w_n != w0) s_if.wvalid = 1'b0;
    end
    chk({tag, "_hs_timeout"}, {s_if.awvalid, s_if.wvalid}, 2'b00);
  endtask

  task automatic finish_b(input string tag, input logic [1:0] exp_resp);
    for (int k = 0; k < 200 && !s_if.bvalid[0]; k++) step();
    chk({tag, "_bvalid"}, s_if.bvalid, 1'b1);
    chk({tag, "_bresp"}, s_if.bresp, exp_resp);
    s_if.bready = 1'b1;
    step();
    s_if.bready = 1'b0;
    chk({tag, "_ready_after_b"}, {s_if.awready, s_if.wready, s_if.bvalid, busy}, 4'b1100);
  endtask

  initial begin
    rst          = 1'b1;
    m_enable     = '0;
    s_if.awaddr  = '0;
    s_if.awprot  = '0;
    s_if.awvalid = 1'b0;
    s_if.wdata   = '0;
    s_if.wstrb   = '0;
    s_if.wvalid  = 1'b0;
    s_if.bready  = 1'b0;
    aw_rdy_en    = '1;
    for (int i = 0; i < M; i++) begin
      resp_cfg[i] = RESP_OKAY;
      b_delay[i]  = 0;
    end

    // Reset values
    repeat (3) step();
    chk("rst_slave", {s_if.awready, s_if.wready, s_if.bvalid, busy, s_if.bresp}, 6'b0);
    chk("rst_mvalid", {m_if.awvalid, m_if.wvalid, m_if.bready}, 12'h000);
    chk("rst_mpayload", {m_if.awaddr, m_if.awprot, m_if.wstrb}, 156'h0);
    chk("rst_mdata", m_if.wdata, 128'h0);
    rst = 1'b0;
    step();
    chk("rel_ready", {s_if.awready, s_if.wready}, 2'b11);

    // Full broadcast, minimum latency
    m_enable    = 4'b1111;
    s_if.awaddr = 32'h0000_1000;
    s_if.awprot = 3'd0;
    s_if.wdata  = 32'hDEAD_BEEF;
    s_if.wstrb  = 4'hF;
    snap();
    send(1'b1, 1'b1, "t1");
    chk("t1_busy", busy, 1'b1);
    chk("t1_mvalid", {m_if.awvalid, m_if.wvalid}, 8'hFF);
    finish_b("t1", RESP_OKAY);
    chk("t1_latency", 32'(bv_cyc - cap_cyc()), 32'd3);
    chk("t1_awaddr", m_if.awaddr, {4{32'h0000_1000}});
    chk("t1_wdata", m_if.wdata, {4{32'hDEAD_BEEF}});
    chk("t1_wstrb", m_if.wstrb, 16'hFFFF);
    chk("t1_aw_per_lane", delta(0), 32'h0101_0101);

    // W two cycles ahead of AW
    s_if.awaddr = 32'h0000_2000;
    s_if.awprot = 3'd2;
    s_if.wdata  = 32'h1234_5678;
    s_if.wstrb  = 4'h3;
    snap();
    send(1'b0, 1'b1, "t2w");
    chk("t2_wready_low", {s_if.awready, s_if.wready}, 2'b10);
    step();
    chk("t2_no_mvalid", {m_if.awvalid, m_if.wvalid, busy}, 9'h000);
    s_if.wdata = 32'hFFFF_FFFF;
    send(1'b1, 1'b0, "t2aw");
    chk("t2_mvalid", {m_if.awvalid, m_if.wvalid}, 8'hFF);
    finish_b("t2", RESP_OKAY);
    chk("t2_wdata_held", m_if.wdata, {4{32'h1234_5678}});
    chk("t2_wstrb", m_if.wstrb, 16'h3333);
    chk("t2_awprot", m_if.awprot, 12'h492);
    chk("t2_aw_per_lane", delta(0), 32'h0101_0101);
    chk("t2_w_per_lane", delta(1), 32'h0101_0101);

    // Sparse enable, staggered responses, enable changed after capture
    m_enable    = 4'b0101;
    b_delay[2]  = 10;
    s_if.awaddr = 32'h0000_3000;
    s_if.wdata  = 32'h0BAD_F00D;
    s_if.wstrb  = 4'hF;
    snap();
    send(1'b1, 1'b1, "t3");
    m_enable = 4'b1111;
    finish_b("t3", RESP_OKAY);
    chk("t3_aw_per_lane", delta(0), 32'h0001_0001);
    chk("t3_w_per_lane", delta(1), 32'h0001_0001);
    chk("t3_b_per_lane", delta(2), 32'h0001_0001);
    chk("t3_lane_gap", 32'(b_cyc[2] - b_cyc[0]), 32'd10);
    chk("t3_bvalid_cycle", 32'(bv_cyc - b_cyc[2]), 32'd1);
    b_delay[2] = 0;

    // Response merge: DECERR dominates, then SLVERR alone
    m_enable    = 4'b1111;
    resp_cfg[1] = RESP_SLVERR;
    resp_cfg[3] = RESP_DECERR;
    b_delay[3]  = 4;
    send(1'b1, 1'b1, "t4a");
    finish_b("t4a", RESP_DECERR);
    resp_cfg[3] = RESP_OKAY;
    b_delay[3]  = 0;
    b_delay[1]  = 5;
    send(1'b1, 1'b1, "t4b");
    finish_b("t4b", RESP_SLVERR);
    resp_cfg[1] = RESP_OKAY;
    b_delay[1]  = 0;

    // Empty enable: immediate DECERR, no master traffic
    m_enable = 4'b0000;
    snap();
    send(1'b1, 1'b1, "t5");
    finish_b("t5", RESP_DECERR);
    chk("t5_latency", 32'(bv_cyc - cap_cyc()), 32'd1);
    chk("t5_aw_per_lane", delta(0), 32'h0);
    chk("t5_w_per_lane", delta(1), 32'h0);

    // Reset while lanes are stalled on AW
    m_enable  = 4'b1111;
    aw_rdy_en = 4'b0000;
    send(1'b1, 1'b1, "t6");
    step();
    chk("t6_stalled", {m_if.awvalid, m_if.wvalid, busy}, 9'h1E1);
    rst = 1'b1;
    step();
    chk("t6_rst_mvalid", {m_if.awvalid, m_if.wvalid, m_if.bready}, 12'h000);
    chk("t6_rst_slave", {s_if.awready, s_if.wready, s_if.bvalid, busy}, 4'b0000);
    rst = 1'b0;
    step();
    chk("t6_rel_ready", {s_if.awready, s_if.wready}, 2'b11);
    aw_rdy_en   = 4'b1111;
    s_if.awaddr = 32'h0000_4000;
    s_if.wdata  = 32'hCAFE_F00D;
    snap();
    send(1'b1, 1'b1, "t6b");
    finish_b("t6b", RESP_OKAY);
    chk("t6b_wdata", m_if.wdata, {4{32'hCAFE_F00D}});
    chk("t6b_aw_per_lane", delta(0), 32'h0101_0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
